// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a req/gnt/rvalid data bus, stalls the pipeline, formats loads.
// Optional macro MISALIGN_TRAP_EN: adds misalign_o and suppresses misaligned accesses instead of issuing them.
module mem_stage_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        bus_err_o,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign_o,
`endif
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [29:0] waddr_q, waddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        memop, start, timeout;
  logic [15:0] cnt_inc;
  logic [3:0]  req_be;
  logic [31:0] req_wdata, load_fmt;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign memop = mem_valid & (is_load | is_store) & ~rst;

`ifdef MISALIGN_TRAP_EN
  logic misalign_hit;
  // Halves need addr[0] clear; words (funct3[1] set) need addr[1:0] clear.
  assign misalign_hit = ((funct3[1:0] == 2'b01) && addr[0]) || (funct3[1] && (addr[1:0] != 2'b00));
  assign misalign_o   = (state_q == IDLE) && memop && misalign_hit;
  assign start        = memop & ~misalign_hit;
`else
  assign start = memop;
`endif

  assign cnt_inc = cnt_q + 16'd1;
  assign timeout = (cnt_inc == 16'(MAX_WAIT));

  // Lane alignment of the request taken straight from the M-stage inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_be    = 4'b1111;
    req_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_be    = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign load_byte = bus_rdata[{off_q, 3'b000} +: 8];
  assign load_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    case (funct3_q)
      3'b000:  load_fmt = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_fmt = {24'd0, load_byte};
      3'b001:  load_fmt = {{16{load_half[15]}}, load_half};
      3'b101:  load_fmt = {16'd0, load_half};
      default: load_fmt = bus_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    waddr_d   = waddr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    bus_req   = 1'b0;
    stall_o   = 1'b0;
    bus_we    = we_q;
    bus_addr  = {waddr_q, 2'b00};
    bus_be    = be_q;
    bus_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        bus_we    = is_store;
        bus_addr  = {addr[31:2], 2'b00};
        bus_be    = req_be;
        bus_wdata = req_wdata;
        if (start) begin
          bus_req  = 1'b1;
          stall_o  = 1'b1;
          we_d     = is_store;
          waddr_d  = addr[31:2];
          be_d     = req_be;
          wdata_d  = req_wdata;
          funct3_d = funct3;
          off_d    = addr[1:0];
          cnt_d    = 16'd0;
          state_d  = bus_gnt ? WAIT_RESP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        bus_req = 1'b1;
        stall_o = 1'b1;
        cnt_d   = cnt_inc;
        if (timeout) begin
          state_d = DONE;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end else if (bus_gnt) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        stall_o = 1'b1;
        cnt_d   = cnt_inc;
        // A response arriving in the last budgeted cycle still wins over the abort.
        if (bus_rvalid) begin
          state_d = DONE;
          if (!we_q) rdata_d = load_fmt;
        end else if (timeout) begin
          state_d = DONE;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset silences the bus and releases the pipeline even mid-access.
    if (rst) begin
      bus_req = 1'b0;
      stall_o = 1'b0;
    end
  end

  // NOTE: reset here is synchronous (sampled on clk) to match the surrounding pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      we_q     <= 1'b0;
      waddr_q  <= 30'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign bus_err_o = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized accesses against a behavioural model.
module tb_mem_stage_lsu;

  logic        clk, rst, mem_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall_o, bus_err_o, bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] rdata_o, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdata = 32'd0;

  mem_stage_lsu #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall_o(stall_o), .rdata_o(rdata_o),
    .bus_err_o(bus_err_o),
`ifdef MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---- behavioural reference model ----
  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned off;
    off = a % 4;
    if (f3[1:0] == 2'b00) return 4'(1 << off);
    if (f3[1:0] == 2'b01) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'b00) return (wd % 256) * 32'h0101_0101;
    if (f3[1:0] == 2'b01) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
    logic [31:0] v;
    if (f3[1:0] == 2'b00) begin
      v = (d >> (8 * (a % 4))) % 256;
      if (!f3[2] && v >= 128) v = v - 32'd256;
    end else if (f3[1:0] == 2'b01) begin
      v = (d >> (16 * ((a % 4) / 2))) % 65536;
      if (!f3[2] && v >= 32768) v = v - 32'd65536;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // One complete access: gd cycles of gnt delay, rvalid rd cycles after the grant.
  task automatic run_access(input string tag, input bit st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input int gd,
                            input int rd, input logic [31:0] rdat, input bit rv_early);
    logic [70:0] exp_v, obs_v;
    exp_v = {1'b1, st, a[31:2], 2'b00, model_be(f3, a), st ? model_wdata(f3, wd) : 32'd0, 1'b1};
    mem_valid = 1'b1; is_load = !st; is_store = st; funct3 = f3; addr = a; wdata = wd;
    bus_gnt = (gd == 0);
    bus_rvalid = rv_early ? 1'b1 : 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    #1;
    obs_v = {bus_req, bus_we, bus_addr, bus_be, st ? bus_wdata : 32'd0, stall_o};
    n_checks++;
    if (obs_v !== exp_v) begin
      n_fail++; $display("FAIL %s issue: got %h exp %h", tag, obs_v, exp_v);
    end
    @(posedge clk); #1;
    for (int k = 1; k <= gd; k++) begin
      addr = $urandom; wdata = $urandom; bus_gnt = (k == gd);
      bus_rvalid = rv_early ? 1'b1 : 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      #1;
      obs_v = {bus_req, bus_we, bus_addr, bus_be, st ? bus_wdata : 32'd0, stall_o};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL %s hold%0d: got %h exp %h", tag, k, obs_v, exp_v);
      end
      @(posedge clk); #1;
    end
    for (int k = 1; k <= rd; k++) begin
      bus_gnt = 1'b0; bus_rvalid = (k == rd); bus_rdata = (k == rd) ? rdat : $urandom;
      #1;
      n_checks++;
      if ({bus_req, stall_o, bus_err_o, rdata_o} !== {1'b0, 1'b1, 1'b0, exp_rdata}) begin
        n_fail++; $display("FAIL %s resp_wait%0d: req/stall/err/rdata %b%b%b %h exp 010 %h",
                           tag, k, bus_req, stall_o, bus_err_o, rdata_o, exp_rdata);
      end
      @(posedge clk); #1;
    end
    if (!st) exp_rdata = model_load(f3, a, rdat);
    bus_rvalid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    #1;
    n_checks++;
    if ({stall_o, bus_req, bus_err_o, rdata_o} !== {3'b000, exp_rdata}) begin
      n_fail++; $display("FAIL %s done: stall/req/err/rdata %b%b%b %h exp 000 %h",
                         tag, stall_o, bus_req, bus_err_o, rdata_o, exp_rdata);
    end
    mem_valid = 1'b0; bus_rvalid = 1'b0; bus_gnt = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    addr = 32'h100; wdata = 32'd0; bus_gnt = 1'b1; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    #1;
    n_checks++;
    if ({bus_req, stall_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_comb: req/stall %b%b exp 00", bus_req, stall_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rdata_o, bus_err_o, bus_req, stall_o} !== 35'd0) begin
      n_fail++; $display("FAIL reset_state: rdata %h err %b req %b stall %b exp all 0",
                         rdata_o, bus_err_o, bus_req, stall_o);
    end
    rst = 1'b0; is_load = 1'b0; bus_gnt = 1'b0;
    #1;
    n_checks++;
    if ({bus_req, stall_o} !== 2'b00) begin
      n_fail++; $display("FAIL nonmem_op: req/stall %b%b exp 00", bus_req, stall_o);
    end
    mem_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_plan_loads;
    run_access("lw_100", 1'b0, 3'b010, 32'h100, 32'd0, 0, 1, 32'hDEAD_BEEF, 1'b0);
    run_access("lb_203", 1'b0, 3'b000, 32'h203, 32'd0, 0, 1, 32'h80FF_1234, 1'b0);
    run_access("lbu_203", 1'b0, 3'b100, 32'h203, 32'd0, 1, 2, 32'h80FF_1234, 1'b0);
    run_access("lh_106", 1'b0, 3'b001, 32'h106, 32'd0, 0, 1, 32'h9876_0001, 1'b0);
    run_access("lhu_106", 1'b0, 3'b101, 32'h106, 32'd0, 0, 1, 32'h9876_0001, 1'b0);
  endtask

  task automatic test_store_gnt_delay;
    run_access("sh_102", 1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 3, 1, 32'h5555_5555, 1'b0);
    run_access("sb_301", 1'b1, 3'b000, 32'h301, 32'h1234_56A7, 0, 2, 32'h0, 1'b0);
  endtask

  task automatic test_gnt_rvalid_same;
    run_access("gnt_rv_same", 1'b0, 3'b010, 32'h40, 32'd0, 1, 2, 32'h600D_F00D, 1'b1);
  endtask

  task automatic test_random;
    logic [2:0]  ld_f3 [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    logic [2:0]  st_f3 [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
    logic [2:0]  f3;
    logic [31:0] a;
    bit          st;
    int          gd, rd;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? st_f3[$urandom_range(0, 3)] : ld_f3[$urandom_range(0, 7)];
      a  = $urandom;
`ifdef MISALIGN_TRAP_EN
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      else if (f3[1]) a[1:0] = 2'b00;
`endif
      gd = $urandom_range(0, 2);
      rd = $urandom_range(1, 3 - gd);
      run_access($sformatf("rand%0d", i), st, f3, a, $urandom, gd, rd, $urandom, 1'b0);
    end
  endtask

  task automatic test_timeout;
    for (int sc = 0; sc < 2; sc++) begin
      run_access("to_pre", 1'b0, 3'b010, 32'h300, 32'd0, 0, 1, 32'h1234_5678, 1'b0);
      mem_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h304;
      bus_gnt = (sc == 0); bus_rvalid = 1'b0;
      #1;
      n_checks++;
      if ({bus_req, stall_o} !== 2'b11) begin
        n_fail++; $display("FAIL to%0d_issue: req/stall %b%b exp 11", sc, bus_req, stall_o);
      end
      @(posedge clk); #1;
      for (int k = 1; k <= 4; k++) begin
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
        n_checks++;
        if ({bus_req, stall_o, bus_err_o, rdata_o} !== {(sc == 1), 1'b1, 1'b0, exp_rdata}) begin
          n_fail++; $display("FAIL to%0d_wait%0d: req/stall/err %b%b%b rdata %h", sc, k,
                             bus_req, stall_o, bus_err_o, rdata_o);
        end
        @(posedge clk); #1;
      end
      exp_rdata = 32'd0;
      #1;
      n_checks++;
      if ({stall_o, bus_req, bus_err_o, rdata_o} !== {3'b001, 32'd0}) begin
        n_fail++; $display("FAIL to%0d_abort: stall/req/err %b%b%b rdata %h exp 001 0", sc,
                           stall_o, bus_req, bus_err_o, rdata_o);
      end
      mem_valid = 1'b0;
      @(posedge clk); #1;
      bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
      #1;
      n_checks++;
      if ({stall_o, bus_req, bus_err_o} !== 3'b000) begin
        n_fail++; $display("FAIL to%0d_after: stall/req/err %b%b%b exp 000", sc,
                           stall_o, bus_req, bus_err_o);
      end
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      #1;
      n_checks++;
      if (rdata_o !== exp_rdata) begin
        n_fail++; $display("FAIL to%0d_late_rvalid: rdata %h exp %h", sc, rdata_o, exp_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    run_access("rst_pre", 1'b0, 3'b010, 32'h500, 32'd0, 0, 1, 32'hA5A5_0F0F, 1'b0);
    mem_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h504;
    bus_gnt = 1'b1; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; bus_gnt = 1'b0;
    #1;
    n_checks++;
    if ({bus_req, stall_o} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_comb: req/stall %b%b exp 00", bus_req, stall_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_valid = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    exp_rdata = 32'd0;
    #1;
    n_checks++;
    if ({bus_req, stall_o, rdata_o} !== {2'b00, exp_rdata}) begin
      n_fail++; $display("FAIL rst_mid_idle: req/stall %b%b rdata %h exp 00 0",
                         bus_req, stall_o, rdata_o);
    end
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    #1;
    n_checks++;
    if ({rdata_o, bus_err_o, stall_o} !== {exp_rdata, 2'b00}) begin
      n_fail++; $display("FAIL rst_mid_discard: rdata %h err %b stall %b exp 0 0 0",
                         rdata_o, bus_err_o, stall_o);
    end
    @(posedge clk); #1;
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign;
    logic [31:0] a_tab [2] = '{32'h101, 32'h203};
    logic [2:0]  f_tab [2] = '{3'b010, 3'b001};
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = f_tab[i]; addr = a_tab[i];
      bus_gnt = 1'b1; bus_rvalid = 1'b0;
      #1;
      n_checks++;
      if ({misalign_o, bus_req, stall_o} !== 3'b100) begin
        n_fail++; $display("FAIL misalign%0d: misalign/req/stall %b%b%b exp 100", i,
                           misalign_o, bus_req, stall_o);
      end
      mem_valid = 1'b0; bus_gnt = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({misalign_o, stall_o, rdata_o} !== {2'b00, exp_rdata}) begin
        n_fail++; $display("FAIL misalign%0d_after: misalign/stall %b%b rdata %h exp 00 %h", i,
                           misalign_o, stall_o, rdata_o, exp_rdata);
      end
    end
    run_access("misalign_post", 1'b0, 3'b010, 32'h104, 32'd0, 0, 1, 32'h0BAD_CAFE, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_plan_loads();
    test_store_gnt_delay();
    test_gnt_rvalid_same();
    test_random();
    test_timeout();
    test_reset_mid();
`ifdef MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
